// File: rtl/div_share_arbiter_pkg.sv
// Shared definitions for the two-requester divider-sharing arbiter:
// FSM encoding, defaults and the divide-by-zero quotient fill.
package div_share_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StLoad    = 2'd1,
        StRun     = 2'd2,
        StCapture = 2'd3
    } state_e;

    localparam int unsigned DefaultWidth   = 32;
    localparam int unsigned DefaultTimeout = 1023;

    // Divide-by-zero returns an all-ones quotient; replicated to WIDTH at the use site.
    localparam logic DzQuotientBit = 1'b1;

endpackage

// File: rtl/div_share_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick: on contention the requester that
// was not served last wins.
module rr_arbiter2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic valid_o,
    output logic grant_o
);

    always_comb begin
        valid_o = req0_i | req1_i;
        if (req0_i && req1_i) begin
            grant_o = ~last_grant_i;
        end else begin
            grant_o = req1_i;
        end
    end

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one sequential divider between two requesters: round-robin grant,
// operand load, Run/Ready handshake, divide-by-zero bypass and a Run watchdog.
module div_share_arbiter
    import div_share_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH   = DefaultWidth,
    parameter int unsigned TIMEOUT = DefaultTimeout,
    parameter int unsigned CNT_W   = 10
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] dividend0,
    input  logic [WIDTH-1:0] dividend1,
    input  logic [WIDTH-1:0] divisor0,
    input  logic [WIDTH-1:0] divisor1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             dz,
    output logic             tmo,
    output logic             div_Reset,
    output logic             div_Run,
    output logic [WIDTH-1:0] div_Dividend,
    output logic [WIDTH-1:0] div_Divisor,
    input  logic             div_Ready,
    input  logic [WIDTH-1:0] div_Quotient,
    input  logic [WIDTH-1:0] div_Remainder
);

    state_e           state_q, state_d;
    logic             grant_q, grant_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dz_q, dz_d;
    logic             tmo_q, tmo_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;

    logic             arb_valid;
    logic             arb_grant;
    logic [WIDTH-1:0] sel_dividend;
    logic [WIDTH-1:0] sel_divisor;

    rr_arbiter2 u_rr_arbiter2 (
        .req0_i       (req0),
        .req1_i       (req1),
        .last_grant_i (last_grant_q),
        .valid_o      (arb_valid),
        .grant_o      (arb_grant)
    );

    assign sel_dividend = arb_grant ? dividend1 : dividend0;
    assign sel_divisor  = arb_grant ? divisor1  : divisor0;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        dvd_d        = dvd_q;
        dvs_d        = dvs_q;
        cnt_d        = cnt_q;
        quotient_d   = quotient_q;
        remainder_d  = remainder_q;
        dz_d         = dz_q;
        tmo_d        = tmo_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Flags stay up through the done cycle, then drop here.
                dz_d  = 1'b0;
                tmo_d = 1'b0;
                if (arb_valid) begin
                    grant_d = arb_grant;
                    dvd_d   = sel_dividend;
                    dvs_d   = sel_divisor;
                    if (sel_divisor == '0) begin
                        quotient_d  = {WIDTH{DzQuotientBit}};
                        remainder_d = sel_dividend;
                        dz_d        = 1'b1;
                        state_d     = StCapture;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                cnt_d   = '0;
                state_d = StRun;
            end
            StRun: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (div_Ready) begin
                    quotient_d  = div_Quotient;
                    remainder_d = div_Remainder;
                    dz_d        = 1'b0;
                    tmo_d       = 1'b0;
                    state_d     = StCapture;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th Run cycle without Ready.
                    quotient_d  = '0;
                    remainder_d = '0;
                    tmo_d       = 1'b1;
                    state_d     = StCapture;
                end
            end
            StCapture: begin
                done0_d      = ~grant_q & req0;
                done1_d      = grant_q & req1;
                last_grant_d = grant_q;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            dvd_q        <= '0;
            dvs_q        <= '0;
            cnt_q        <= '0;
            quotient_q   <= '0;
            remainder_q  <= '0;
            dz_q         <= 1'b0;
            tmo_q        <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            dvd_q        <= dvd_d;
            dvs_q        <= dvs_d;
            cnt_q        <= cnt_d;
            quotient_q   <= quotient_d;
            remainder_q  <= remainder_d;
            dz_q         <= dz_d;
            tmo_q        <= tmo_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
        end
    end

    always_comb begin
        done0        = done0_q;
        done1        = done1_q;
        Quotient     = quotient_q;
        Remainder    = remainder_q;
        dz           = dz_q;
        tmo          = tmo_q;
        div_Reset    = (state_q == StLoad);
        div_Run      = (state_q == StRun);
        div_Dividend = (state_q != StIdle) ? dvd_q : '0;
        div_Divisor  = (state_q != StIdle) ? dvs_q : '0;
    end

endmodule

// File: doc/div_share_arbiter.md
Name: div_share_arbiter

Overview:
- Shares the single sequential divider datapath (divider plus its Control sequencer) between two requesters.
- Arbitrates round-robin and loads the winner's operands.
- Resets the divider, holds Run until Ready, then latches Quotient/Remainder and returns them with a one-cycle done pulse.
- Short-circuits divide-by-zero and aborts hung operations via a watchdog.

Parameters:
- WIDTH, 32, operand/result width
- TIMEOUT, 1023, max cycles in RUN before abort
- CNT_W, 10, watchdog counter width (must satisfy 2^CNT_W > TIMEOUT)

Ports:
- clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- req0, req1  in  1 each  request level; held high with operands stable until matching done
- dividend0, dividend1  in  WIDTH each  dividends
- divisor0, divisor1  in  WIDTH each  divisors
- done0, done1  out  1 each  one-cycle completion pulse to requester
- Quotient, Remainder  out  WIDTH each  result bus, valid while done0/done1 high, held afterwards
- dz  out  1  divide-by-zero flag, valid with done
- tmo  out  1  timeout flag, valid with done
- div_Reset  out  1  synchronous reset to divider/Control
- div_Run  out  1  Run to Control
- div_Dividend, div_Divisor  out  WIDTH each  operands to divider
- div_Ready  in  1  Ready from Control
- div_Quotient, div_Remainder  in  WIDTH each  divider results

Behaviour:
- Reset values (async, immediate): state IDLE, last_grant=1 (so req0 wins first tie), all outputs 0, counter 0.
- States: IDLE, LOAD, RUN, CAPTURE.
- IDLE:
  - Grant = the sole requester; if both request, the one not equal to last_grant.
  - Register grant, dividend, divisor.
  - If the latched divisor is 0: go to CAPTURE with dz=1, Quotient = all ones, Remainder = dividend. The divider is not touched.
  - Otherwise go to LOAD.
- LOAD (1 cycle): div_Reset=1, div_Run=0, div_Dividend/div_Divisor driven from latched copies (driven in every non-IDLE state). Next: RUN, counter cleared.
- RUN:
  - div_Run=1 and counter increments each cycle.
  - div_Ready=1 → CAPTURE: latch div_Quotient/div_Remainder into Quotient/Remainder, dz=0, tmo=0.
  - counter==TIMEOUT without Ready → CAPTURE with tmo=1, Quotient/Remainder=0.
  - div_Ready is ignored in every state other than RUN.
- CAPTURE (1 cycle):
  - done of the granted requester = 1, only if that req is still high. If req dropped, the result is discarded and no done is issued.
  - Update last_grant; div_Run=0; next IDLE.
  - dz/tmo clear on the next cycle.
- Latency: non-zero divisor = 2 + Ready delay + 1 cycles from grant to done. dz = 2 cycles (IDLE latch → CAPTURE → done visible).
- Requester deassert mid-RUN: operation completes, result discarded, arbiter returns to IDLE normally.
- A requester whose done just pulsed and still holds req is treated as a new request. Round-robin still favours the other requester.
- Simultaneous req0/req1 rise: fairness by last_grant, as above.
- Reset mid-operation: everything returns to reset values at once, no done is issued. The divider is re-initialised by the next LOAD.
- Operands are sampled only at grant; later changes are ignored until the next grant.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, CAPTURE=2'd3), the divide-by-zero quotient constant (all ones), default WIDTH/TIMEOUT.
- One natural sub-module: rr_arbiter2 (combinational two-way round-robin pick from req0/req1/last_grant). Everything else stays in the top module.

Test Plan:
- Single request: req0=1, dividend0=100, divisor0=7, divider model raises Ready after 170 Run cycles → one LOAD cycle with div_Reset=1, then done0 pulse with Quotient=14, Remainder=2, dz=0, tmo=0; done1 stays 0.
- Contention: req0 and req1 rise in the same cycle (20/3 and 9/4) → req0 served first (Q=6, R=2), then req1 (Q=2, R=1). Both held again → order alternates 1,0,1.
- Divide-by-zero: req1=1, dividend1=55, divisor1=0 → div_Run never asserts; done1 two cycles after request with Quotient=0xFFFFFFFF, Remainder=55, dz=1.
- Timeout: model never asserts Ready, TIMEOUT=16 → div_Run high exactly 16 cycles; done0 with tmo=1 and Quotient=Remainder=0; next request serviced normally.
- Dropped request: req0 deasserts during RUN → no done0 pulse; FSM returns to IDLE; a pending req1 is granted next.
- Async reset during RUN: Reset pulsed between clock edges → all outputs 0 immediately, state IDLE, no done; a subsequent request completes correctly.
